// File: rtl/pipemem_io_gen.sv
// pipemem_io_gen: MEM stage with byte-lane data RAM, memory-mapped I/O ports and a registered load result
//   clock/resetn      : single clock, async active-low reset
//   mwmem/mrmem       : store / load request (both at once is treated as illegal)
//   msize/msign/malu  : access size (00 b, 01 h, 10 w), load sign-extend, effective address
//   mb                : right-aligned store data
//   in_ports          : N_IN async 32-bit inputs, double-flop synchronised
//   mmo/mvalid        : load result one cycle after the load, valid pulse
//   misalign          : pulse one cycle after an illegal (dropped) access
//   out_ports         : N_OUT 32-bit output registers
//   Optional macro IO_CHANGE_FLAG_EN: sticky per-input change flags readable (and cleared) at I/O index 7
module pipemem_io_gen #(
  parameter int MEM_AW = 5,
  parameter int N_IN   = 2,
  parameter int N_OUT  = 4,
  parameter int IO_BIT = 7
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                mwmem,
  input  logic                mrmem,
  input  logic [1:0]          msize,
  input  logic                msign,
  input  logic [31:0]         malu,
  input  logic [31:0]         mb,
  input  logic [32*N_IN-1:0]  in_ports,
  output logic [31:0]         mmo,
  output logic                mvalid,
  output logic                misalign,
  output logic [32*N_OUT-1:0] out_ports
);
  logic io, legal, wr_ok, rd_ok, bad, unused_ok;
  logic [MEM_AW-1:0] widx;
  logic [31:0] ioidx, io_rd, ram_rd, rd_word, wdata, mmo_d;
  logic [3:0] we;
  logic [7:0] lane;
  logic [15:0] half;
  logic [31:0] mem [2**MEM_AW];
  logic [31:0] s1_q [N_IN];
  logic [31:0] s2_q [N_IN];
  logic [31:0] out_q [N_OUT];
  logic [31:0] mmo_q;
  logic mvalid_q, misalign_q;
  logic [7:0] flags_q, flags_d;
  assign io        = malu[IO_BIT];
  assign widx      = malu[MEM_AW+1:2];
  assign ioidx     = {29'd0, malu[4:2]};
  assign unused_ok = ^malu;
  // I/O only supports word accesses; reserved size and simultaneous requests are dropped
  assign legal = !(mwmem && mrmem) && !(io && msize != 2'b10) &&
                 (msize == 2'b00 || (msize == 2'b01 && !malu[0]) || (msize == 2'b10 && malu[1:0] == 2'b00));
  assign wr_ok = mwmem && legal;
  assign rd_ok = mrmem && legal;
  assign bad   = (mwmem || mrmem) && !legal;
  always_comb begin
    io_rd = '0;
    for (int k = 0; k < N_IN; k++) if (ioidx == k) io_rd = s2_q[k];
    for (int k = 0; k < N_OUT; k++) if (ioidx == N_IN + k) io_rd = out_q[k];
`ifdef IO_CHANGE_FLAG_EN
    if (ioidx == 7) io_rd = {24'd0, flags_q};
`endif
  end
  assign ram_rd  = mem[widx];
  assign rd_word = io ? io_rd : ram_rd;
  assign lane    = malu[1] ? (malu[0] ? rd_word[31:24] : rd_word[23:16]) : (malu[0] ? rd_word[15:8] : rd_word[7:0]);
  assign half    = malu[1] ? rd_word[31:16] : rd_word[15:0];
  assign mmo_d   = msize == 2'b00 ? {{24{msign & lane[7]}}, lane} :
                   msize == 2'b01 ? {{16{msign & half[15]}}, half} : rd_word;
  // replicate store data across lanes so each enabled lane picks its own slice
  assign wdata = msize == 2'b00 ? {4{mb[7:0]}} : msize == 2'b01 ? {2{mb[15:0]}} : mb;
  assign we    = (!wr_ok || io) ? 4'b0000 :
                 msize == 2'b00 ? 4'b0001 << malu[1:0] :
                 msize == 2'b01 ? (malu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clock)
    for (int l = 0; l < 4; l++) if (we[l]) mem[widx][8*l +: 8] <= wdata[8*l +: 8];
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      for (int k = 0; k < N_IN; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      mmo_q      <= '0;
      mvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        s1_q[k] <= in_ports[32*k +: 32];
        s2_q[k] <= s1_q[k];
      end
      for (int k = 0; k < N_OUT; k++) if (wr_ok && io && ioidx == k) out_q[k] <= mb;
      if (rd_ok) mmo_q <= mmo_d;
      mvalid_q   <= rd_ok;
      misalign_q <= bad;
    end
`ifdef IO_CHANGE_FLAG_EN
  // a change landing on the same edge as the clearing read wins
  always_comb begin
    flags_d = (rd_ok && io && ioidx == 7) ? 8'd0 : flags_q;
    for (int k = 0; k < N_IN; k++) if (s1_q[k] != s2_q[k]) flags_d[k] = 1'b1;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) flags_q <= '0;
    else flags_q <= flags_d;
`else
  assign flags_d = '0;
  assign flags_q = flags_d;
`endif
  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_ports[32*g +: 32] = out_q[g];
  end
  assign mmo      = mmo_q;
  assign mvalid   = mvalid_q;
  assign misalign = misalign_q;
endmodule

// File: doc/pipemem_io_gen.md
Name: pipemem_io_gen

Overview:
Parametrised MEM-stage block for the pipelined CPU: data RAM plus memory-mapped I/O on a single clock. Adds byte/half/word stores, sign/zero-extended loads, and synchronised input ports. Supports configurable RAM depth and configurable input/output port counts. Sits between EX/MEM and MEM/WB; its load result is registered and forms part of the MEM/WB boundary.

Parameters:
MEM_AW, 5, word-address bits of data RAM (depth 2^MEM_AW words)
N_IN, 2, number of 32-bit input ports (1..8)
N_OUT, 4, number of 32-bit output ports (1..8)
IO_BIT, 7, address bit selecting I/O (1) vs RAM (0); must satisfy IO_BIT >= MEM_AW+2

Ports:
clock  in  1  single system clock, rising edge
resetn  in  1  asynchronous active-low reset
mwmem  in  1  store request this cycle
mrmem  in  1  load request this cycle (mutually exclusive with mwmem)
msize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
msign  in  1  load sign-extend (1) / zero-extend (0)
malu  in  32  effective address
mb  in  32  store data, right-aligned
in_ports  in  32*N_IN  packed asynchronous input ports, port k at [32k+31:32k]
mmo  out  32  load result, registered
mvalid  out  1  one-cycle pulse: mmo holds the result of the load issued the previous cycle
misalign  out  1  one-cycle pulse: previous-cycle access was misaligned or illegal, and was dropped
out_ports  out  32*N_OUT  packed output port registers

Behaviour:
- Reset (async, resetn=0): out_ports=0, input synchronisers=0, mmo=0, mvalid=0, misalign=0, internal load-tracking regs=0. RAM contents are not reset. Release is synchronous to the next rising edge.
- Decode: io = malu[IO_BIT]; RAM word index = malu[MEM_AW+1:2]; I/O index = malu[4:2].
- Alignment:
  - half legal iff malu[0]=0;
  - word legal iff malu[1:0]=00;
  - msize=11 is always illegal;
  - any I/O access with msize!=10 is illegal.
  - Illegal access: no state change; misalign=1 on the next cycle; mvalid=0.
- RAM store: byte lanes written per size/offset. Byte writes lane malu[1:0] with mb[7:0]. Half writes lanes {malu[1],0}+1..0 with mb[15:0]. Word writes all lanes. Completes at the edge.
- I/O store: index k<N_OUT writes out_ports[k] at the edge. Index >= N_OUT is ignored silently (no misalign).
- Input synchronisers: each in_port passes through two flops every cycle, so there are 2 cycles of latency from pin to readable value.
- Load latency is exactly 1 cycle. At edge t the block captures the RAM word (synchronous read), or the I/O value, together with offset, size and sign. During cycle t+1 it drives mmo with the extracted value and mvalid=1.
  - mmo is updated only on a valid load. It holds its value otherwise.
- I/O read value:
  - k<N_IN: second-stage sync value of in_port k;
  - N_IN<=k<N_IN+N_OUT: readback of out_ports[k-N_IN];
  - otherwise 0.
- Extraction: byte = lane malu[1:0]; half = lanes at offset malu[1]. Extend per msign to 32 bits.
- Store at edge t followed by a load of the same address at t+1 returns the new data. There is no read-during-write case, since requests are mutually exclusive.
- mwmem=mrmem=1 is illegal: the block treats it as misaligned, drops the request and pulses misalign.
- Back-to-back loads: mvalid stays high continuously and mmo updates every cycle.
- Reset asserted mid-load: the pending result is lost; mvalid=0 after release.

Optional Feature:
Macro IO_CHANGE_FLAG_EN.
- Defined: a per-input sticky flag is set when the synced value differs from the previous synced value. Reading I/O index 7 returns {24'b0, flags[7:0]}, zero-padded above N_IN. That read clears all flags at the edge; a simultaneous new change takes priority and keeps its flag set. The flags reset to 0.
- Not defined: index 7 follows the normal I/O read rules and no flag logic exists.

Test Plan:
- Reset then word store 0xDEADBEEF to 0x04, load word 0x04 next cycle -> mvalid=1, mmo=0xDEADBEEF one cycle after load.
- Store byte 0x80 to 0x09; load byte signed 0x09 -> mmo=0xFFFFFF80; load byte unsigned -> 0x00000080; load word 0x08 -> 0x00008000 (prior contents 0).
- Half store to 0x0B -> misalign pulses, RAM word 0x08 unchanged. Word load from IO 0x81 -> misalign, mvalid=0.
- Word store 0x12345678 to 0x8C (IO idx 3) -> out_ports[3]=0x12345678 next cycle. Load 0x94 (idx 5 = out readback of port 3 with N_IN=2) -> 0x12345678.
- Drive in_ports[1]=0xA5A5A5A5 and load 0x84 at cycles 1, 2, 3 after the change -> old, old, 0xA5A5A5A5 (2-flop latency); assert resetn=0 mid-load -> mvalid=0, mmo=0.
- With IO_CHANGE_FLAG_EN: toggle in_port0, load 0x9C -> 0x00000001; load again -> 0x00000000.
